// File: rtl/t05_sram_responder.sv
// Responder for single-word SRAM requests: decodes byte address, drives one macro access, then busy_o falls.
// Latency: busy_o high for LATENCY cycles after the sampling edge, then a non-sampling RECOVER cycle.
module t05_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h33000000,
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              r_en,
    input  logic [3:0]        select,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              busy_o,
    output logic              addr_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RECOVER} state_t;

    localparam int              CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 2);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               wr_q, oor_q;

    logic               req, accept, in_range, capture;
    logic [31:0]        offset;
    logic [ADDR_W-1:0]  word;
    logic               busy_nxt, en_nxt, we_nxt, err_nxt;

    assign req    = wr_en | r_en;
    assign accept = (state == IDLE) && req;

    // Low two bits of the byte address drop out with the word shift.
    assign offset   = addr - BASE_ADDR;
    assign word     = ADDR_W'(offset >> 2);
    assign in_range = (addr >= BASE_ADDR) && ((offset >> (ADDR_W + 2)) == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = WAIT;
                cnt_nxt   = WAIT_LOAD;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RECOVER;
                else           cnt_nxt   = cnt - 1'b1;
            end
            RECOVER: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ACCESS) || (state_nxt == WAIT);
        en_nxt   = accept && in_range;
        we_nxt   = en_nxt && wr_en;
        err_nxt  = (state_nxt == RECOVER) && oor_q;
        // Macro read data is valid in the first WAIT cycle only.
        capture  = (state == WAIT) && (cnt == WAIT_LOAD) && !wr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o     <= 1'b0;
            data_o     <= '0;
            addr_err   <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
            wr_q       <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            busy_o     <= busy_nxt;
            addr_err   <= err_nxt;
            sram_en    <= en_nxt;
            sram_we    <= we_nxt;
            sram_wmask <= we_nxt ? select : 4'h0;
            if (accept) begin
                wr_q      <= wr_en;
                oor_q     <= !in_range;
                sram_addr <= word;
                if (wr_en) sram_din <= data_i;
            end
            if (capture) data_o <= oor_q ? 32'h0 : sram_dout;
        end
    end

endmodule

// File: tb/tb_t05_sram_responder.sv
// Bench for t05_sram_responder: directed cases plus random traffic against a flat memory model.
module tb_t05_sram_responder;

    localparam logic [31:0] BASE = 32'h33000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_i;
    logic        wr_en_c, r_en_c;
    logic [3:0]  select_c;
    logic [31:0] addr_c, data_c;

    logic        wr_a, rd_a, wr_b, rd_b;
    logic [31:0] data_o_a, data_o_b, din_a, din_b;
    logic [31:0] dout_a = 32'h0;
    logic [31:0] dout_b = 32'h0;
    logic        busy_a, busy_b, err_a, err_b, en_a, en_b, we_a, we_b;
    logic [3:0]  wm_a, wm_b;
    logic [11:0] sa_a, sa_b;

    logic [31:0] data_o, sram_din;
    logic        busy, addr_err, sram_en, sram_we;
    logic [3:0]  sram_wmask;
    logic [11:0] sram_addr;

    logic [31:0] mem_a [0:4095] = '{default: 32'h0};
    logic [31:0] mem_b [0:4095] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1][0:4095] = '{default: 32'h0};
    logic [31:0] ref_dout [0:1] = '{default: 32'h0};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    bit mon_on = 1'b0;
    bit seen_w [0:4095] = '{default: 1'b0};
    int wr_cnt = 0, dup_cnt = 0, max_word = 0, first_cyc = 0, last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign wr_a = wr_en_c & ~sel_i;
    assign rd_a = r_en_c & ~sel_i;
    assign wr_b = wr_en_c & sel_i;
    assign rd_b = r_en_c & sel_i;

    assign data_o     = sel_i ? data_o_b : data_o_a;
    assign busy       = sel_i ? busy_b : busy_a;
    assign addr_err   = sel_i ? err_b : err_a;
    assign sram_en    = sel_i ? en_b : en_a;
    assign sram_we    = sel_i ? we_b : we_a;
    assign sram_wmask = sel_i ? wm_b : wm_a;
    assign sram_addr  = sel_i ? sa_b : sa_a;
    assign sram_din   = sel_i ? din_b : din_a;

    t05_sram_responder #(.BASE_ADDR(BASE), .ADDR_W(12), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_a), .r_en(rd_a), .select(select_c),
        .addr(addr_c), .data_i(data_c), .data_o(data_o_a), .busy_o(busy_a),
        .addr_err(err_a), .sram_en(en_a), .sram_we(we_a), .sram_wmask(wm_a),
        .sram_addr(sa_a), .sram_din(din_a), .sram_dout(dout_a)
    );

    t05_sram_responder #(.BASE_ADDR(BASE), .ADDR_W(12), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_b), .r_en(rd_b), .select(select_c),
        .addr(addr_c), .data_i(data_c), .data_o(data_o_b), .busy_o(busy_b),
        .addr_err(err_b), .sram_en(en_b), .sram_we(we_b), .sram_wmask(wm_b),
        .sram_addr(sa_b), .sram_din(din_b), .sram_dout(dout_b)
    );

    // Single-port macro models: byte-masked write, registered read.
    always @(posedge clk) begin
        if (en_a) begin
            if (we_a) begin
                for (int b = 0; b < 4; b++)
                    if (wm_a[b]) mem_a[sa_a][8*b +: 8] <= din_a[8*b +: 8];
            end else begin
                dout_a <= mem_a[sa_a];
            end
        end
        if (en_b) begin
            if (we_b) begin
                for (int b = 0; b < 4; b++)
                    if (wm_b[b]) mem_b[sa_b][8*b +: 8] <= din_b[8*b +: 8];
            end else begin
                dout_b <= mem_b[sa_b];
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on && en_a && we_a) begin
            if (wr_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            wr_cnt++;
            if (seen_w[sa_a]) dup_cnt++;
            seen_w[sa_a] = 1'b1;
            if (int'(sa_a) > max_word) max_word = int'(sa_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_in(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * 4096);
    endfunction

    function automatic logic [11:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 4;
        return off[11:0];
    endfunction

    task automatic do_req(input bit inst, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        int busy_n, en_n, err_n, lat;
        bit seen, done, inr;
        logic [11:0] ea, w;
        logic [31:0] ed;
        logic [3:0]  em;
        logic        ewe;
        busy_n = 0; en_n = 0; err_n = 0; seen = 0; done = 0;
        ea = '0; ed = '0; em = '0; ewe = 1'b0;
        inr = is_in(a);
        w   = word_of(a);
        lat = inst ? 4 : 2;
        sel_i = inst; wr_en_c = wr; r_en_c = rd; addr_c = a; select_c = s; data_c = d;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (sram_en) begin
                en_n++; ea = sram_addr; ewe = sram_we; em = sram_wmask; ed = sram_din;
            end
            if (addr_err) err_n++;
            if (busy) begin
                busy_n++;
                if (!seen) begin
                    seen = 1'b1;
                    wr_en_c = 1'b0; r_en_c = 1'b0;
                    addr_c = $urandom; select_c = 4'($urandom); data_c = $urandom;
                end
            end else if (seen) begin
                done = 1'b1;
            end
        end
        chk("completion", 32'(done), 32'd1);
        if (wr) begin
            if (inr)
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[inst][w][8*b +: 8] = d[8*b +: 8];
        end else begin
            ref_dout[inst] = inr ? ref_mem[inst][w] : 32'h0;
        end
        chk("data_o", data_o, ref_dout[inst]);
        @(negedge clk);
        if (addr_err) err_n++;
        chk("busy_cycles", 32'(busy_n), 32'(lat));
        chk("en_cycles", 32'(en_n), 32'(inr));
        chk("addr_err_pulses", 32'(err_n), 32'(!inr));
        if (inr) begin
            chk("sram_addr", 32'(ea), 32'(w));
            chk("sram_we", 32'(ewe), 32'(wr));
            if (wr) begin
                chk("sram_wmask", 32'(em), 32'(s));
                chk("sram_din", ed, d);
            end
        end
    endtask

    initial begin
        int falls;
        bit pb;
        logic [31:0] ra;
        int op, pick;

        rst = 1'b1; sel_i = 1'b0; wr_en_c = 1'b0; r_en_c = 1'b0;
        select_c = 4'h0; addr_c = 32'h0; data_c = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_wmask", 32'(sram_wmask), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_din", sram_din, 32'h0);
        chk("rst_busy4", 32'(busy_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write's ACCESS cycle (word 4000 is never read back)
        wr_en_c = 1'b1; addr_c = BASE + 32'd16000; select_c = 4'hF; data_c = 32'h5A5A5A5A;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_en", 32'(sram_en), 32'd1);
        #2 rst = 1'b1;
        wr_en_c = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_en", 32'(sram_en), 32'd0);
        chk("async_rst_we", 32'(sram_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 1'b0, 1'b1, BASE + 32'h14, 4'h0, 32'h0);

        do_req(1'b0, 1'b1, 1'b0, 32'h33000008, 4'hF, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 1'b1, 32'h33000008, 4'h0, 32'h0);
        chk("readback_deadbeef", data_o, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 1'b0, 32'h33000010, 4'hF, 32'h11223344);
        do_req(1'b0, 1'b1, 1'b0, 32'h33000010, 4'b0010, 32'h0000AA00);
        do_req(1'b0, 1'b0, 1'b1, 32'h33000010, 4'h0, 32'h0);
        chk("byte_merge", data_o, 32'h1122AA44);

        do_req(1'b0, 1'b1, 1'b0, 32'h33000010, 4'h0, 32'hFFFFFFFF);
        do_req(1'b0, 1'b0, 1'b1, 32'h33000010, 4'h0, 32'h0);

        do_req(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        chk("oor_zero_read", data_o, 32'h0);
        do_req(1'b0, 1'b0, 1'b1, 32'h33000010, 4'h0, 32'h0);
        do_req(1'b0, 1'b0, 1'b1, 32'h33004000, 4'h0, 32'h0);
        do_req(1'b0, 1'b1, 1'b0, 32'h32FFFFFC, 4'hF, 32'h12345678);

        // Held write request sweeping the first 2048 words
        sel_i = 1'b0; mon_on = 1'b1;
        wr_en_c = 1'b1; r_en_c = 1'b0; select_c = 4'hF; data_c = 32'h0; addr_c = BASE;
        falls = 0; pb = 1'b0;
        for (int k = 0; k < 2048 * 4 + 40 && falls < 2048; k++) begin
            @(negedge clk);
            if (pb && !busy) begin
                falls++;
                if (falls == 2048) wr_en_c = 1'b0;
                else addr_c = addr_c + 32'd4;
            end
            pb = busy;
        end
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        chk("sweep_falls", 32'(falls), 32'd2048);
        chk("sweep_writes", 32'(wr_cnt), 32'd2048);
        chk("sweep_dups", 32'(dup_cnt), 32'd0);
        chk("sweep_max_word", 32'(max_word), 32'd2047);
        chk("sweep_period", 32'(last_cyc - first_cyc), 32'(2047 * 4));
        for (int i = 0; i < 2048; i++) ref_mem[0][i] = 32'h0;

        // Simultaneous write and read on the LATENCY=4 instance
        do_req(1'b1, 1'b1, 1'b1, BASE + 32'h40, 4'hF, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 1'b1, BASE + 32'h40, 4'h0, 32'h0);
        chk("lat4_readback", data_o, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

        for (int n = 0; n < 80; n++) begin
            op   = $urandom_range(0, 3);
            pick = $urandom_range(0, 9);
            case (pick)
                0:       ra = 32'h0;
                1:       ra = BASE + 32'h4000 + 4 * $urandom_range(0, 15);
                2:       ra = BASE - 32'd4;
                default: ra = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
            endcase
            do_req(1'($urandom_range(0, 1)), (op == 1) || (op == 2), (op != 1),
                   ra, 4'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/t05_sram_responder.md
Name: t05_sram_responder

Overview:
- Responder end of the team's Wishbone-style SRAM request bus. It accepts single-word read and write requests from the SRAM interface (wr_en/r_en/select/addr/data_i) and drives busy_o and data_o back to it.
- Decodes the byte address into a word index, sequences a single-port SRAM macro, and signals completion with a busy_o falling edge.
- Sits between the team-05 SRAM interface and the SRAM macro.

Parameters:
- BASE_ADDR, 32'h33000000, byte address of SRAM word 0.
- ADDR_W, 12, macro word-address width (4096 words, 16 KB).
- LATENCY, 2, busy_o high cycles per transaction. Legal values are LATENCY >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  write request, level.
- r_en  input  1  read request, level.
- select  input  4  byte enables; bit i enables data byte i.
- addr  input  32  byte address.
- data_i  input  32  write data from the initiator.
- data_o  output  32  read data to the initiator.
- busy_o  output  1  transaction in progress.
- addr_err  output  1  one-cycle pulse: the completed request was out of range.
- sram_en  output  1  macro enable.
- sram_we  output  1  macro write enable.
- sram_wmask  output  4  macro byte write mask.
- sram_addr  output  ADDR_W  macro word address.
- sram_din  output  32  macro write data.
- sram_dout  input  32  macro read data, valid the cycle after a read enable.

Behaviour:
- Reset values: state=IDLE, busy_o=0, data_o=0, addr_err=0, sram_en=0, sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0.
- Reset is asynchronous and may occur mid-transaction. It forces IDLE immediately, and sram_en drops in the same cycle. The contents of a write in flight are undefined and must not be checked.
- FSM states: IDLE, ACCESS, WAIT, RECOVER. All macro outputs are registered from latched request registers.
- IDLE, with busy_o=0:
  - If wr_en|r_en: latch op, addr, select and data_i, then go to ACCESS.
  - wr_en and r_en both high: the write wins.
- Address decode:
  - word = (addr - BASE_ADDR) >> 2; addr[1:0] are ignored.
  - The request is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_W.
  - addr=0, which the initiator uses as its idle address, is out of range.
  - Out of range: no macro access, full busy timing is kept, a read returns 32'h0, and addr_err pulses in the RECOVER cycle.
- ACCESS (1 cycle), busy_o=1:
  - sram_en=1 only if in range; sram_addr=word.
  - Write: sram_we=1, sram_wmask=select, sram_din=data_i. select=0 means no byte changes.
  - Read: sram_we=0, full word.
- WAIT (LATENCY-1 cycles, down-counter), busy_o=1:
  - The first WAIT cycle captures sram_dout into data_o for in-range reads.
  - sram_en=0 throughout WAIT.
- RECOVER (1 cycle), busy_o=0:
  - Requests are NOT sampled in this cycle; the next state is IDLE.
  - This gives the initiator one cycle after the busy_o falling edge to advance addr/data before the next sample.
- Timing: request sampled at edge N. busy_o is high for cycles N+1..N+LATENCY and low from N+LATENCY+1. Held requests repeat every LATENCY+2 cycles.
- data_o is valid no later than the busy_o falling edge. It holds until the next read's capture; writes and out-of-range writes leave it unchanged.
- Request changes after acceptance are ignored until the next IDLE.

Test Plan:
1. Reset mid-ACCESS of a write -> busy_o, sram_en and sram_we all 0 combinationally. After release, a read of any address completes normally.
2. wr_en=1, addr=32'h33000008, select=4'hF, data_i=32'hDEADBEEF, then read the same address (LATENCY=2) -> write: busy_o high exactly 2 cycles; sram_addr=2, sram_wmask=4'hF. Read: data_o=32'hDEADBEEF at busy_o fall, addr_err=0.
3. Write 32'h11223344 to 32'h33000010, then write select=4'b0010, data_i=32'h0000AA00 to the same address, then read -> 32'h1122AA44.
4. Hold wr_en=1 and advance addr by 4 on each busy_o fall, 2048 times from 32'h33000000 (the histogram clear pattern) -> exactly 2048 macro writes, words 0..2047, no duplicates. Period is 4 cycles.
5. Read addr=0 and addr=32'h33004000 -> no sram_en; busy_o high 2 cycles; data_o=0; addr_err pulses once per request. Prior data_o is overwritten by 0.
6. wr_en=r_en=1 with LATENCY=4 -> treated as a write; busy_o high 4 cycles; sram_en pulses exactly 1 cycle.
